i2c_arbiter: RTL and testbench

- Shares one I2C front-end command interface between NREQ independent requesters, for example a sensor poller, a power monitor and a software-AXI path.
- Each request carries a full transaction (device, register, direction, length, TX data).
- The arbiter picks a winner round-robin, drives the front-end's dev-addr/reg-num/tx-data/len lines, strobes the start, waits for completion, then returns RX data and fault status to the winner.
- Sits between the requesters and the I2C front-end, in place of direct AXI register control.

---
 rtl/i2c_arb_pkg.sv | 27 ++
 rtl/i2c_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/i2c_arbiter.sv | 171 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C front-end arbiter: field widths, FSM state
// codes, length limits and the watchdog response pattern.
package i2c_arb_pkg;

  localparam int DEV_W  = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 3;

  localparam int MAX_LEN = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE       = 3'd0;
  localparam arb_state_t ST_ISSUE      = 3'd1;
  localparam arb_state_t ST_WAIT_START = 3'd2;
  localparam arb_state_t ST_WAIT_DONE  = 3'd3;
  localparam arb_state_t ST_RESPOND    = 3'd4;

  // A byte count the front-end can execute; anything else is faulted locally.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (int'(len) <= MAX_LEN);
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Command/status lines between the arbiter (master) and the I2C front-end
// (slave).
interface i2c_arbiter_if;
  import i2c_arb_pkg::*;

  logic [DEV_W-1:0]  dev_addr;
  logic [REG_W-1:0]  reg_num;
  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  read_len;
  logic              read_len_wstrobe;
  logic [LEN_W-1:0]  write_len;
  logic              write_len_wstrobe;
  logic [1:0]        status;   // bit0 = idle, bit1 = fault of last transaction
  logic [DATA_W-1:0] rx_data;

  modport master (
    output dev_addr, reg_num, tx_data,
    output read_len, read_len_wstrobe, write_len, write_len_wstrobe,
    input  status, rx_data
  );

  modport slave (
    input  dev_addr, reg_num, tx_data,
    input  read_len, read_len_wstrobe, write_len, write_len_wstrobe,
    output status, rx_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int          pos;
  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IW'(pos);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sharing of one I2C front-end among NREQ transaction requesters.
// Optional completion watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int START_WAIT     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0]       i_req_write,
  input  logic [DEV_W*NREQ-1:0] i_req_dev_addr,
  input  logic [REG_W*NREQ-1:0] i_req_reg_num,
  input  logic [LEN_W*NREQ-1:0] i_req_len,
  input  logic [DATA_W*NREQ-1:0] i_req_tx_data,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic                  o_rsp_fault,
  i2c_arbiter_if.master         fe
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(START_WAIT + 1);

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic            cur_write;
  logic [SW-1:0]   start_cnt;

  logic [NREQ-1:0] rr_grant;
  logic [IW-1:0]   rr_idx;
  logic            rr_any;
  logic            accept;
  logic            fe_idle;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] owner_onehot;

  logic              sel_write;
  logic [DEV_W-1:0]  sel_dev;
  logic [REG_W-1:0]  sel_reg;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_tx;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  assign fe_idle      = fe.status[0];
  // Gating on idle also holds off grants after a reset or watchdog expiry
  // until the front-end has finished whatever it was doing.
  assign accept       = (state == ST_IDLE) && fe_idle && rr_any;
  assign o_req_ready  = accept ? rr_grant : '0;
  assign next_ptr     = (rr_idx == IW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
  assign owner_onehot = NREQ'(1) << owner;

  assign sel_write = i_req_write[rr_idx];
  assign sel_dev   = i_req_dev_addr[rr_idx*DEV_W +: DEV_W];
  assign sel_reg   = i_req_reg_num[rr_idx*REG_W +: REG_W];
  assign sel_len   = i_req_len[rr_idx*LEN_W +: LEN_W];
  assign sel_tx    = i_req_tx_data[rr_idx*DATA_W +: DATA_W];

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
`else
  logic [DATA_W-1:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES) ^ TIMEOUT_DATA;
`endif

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      owner                <= '0;
      cur_write            <= 1'b0;
      start_cnt            <= '0;
      o_rsp_valid          <= '0;
      o_rsp_data           <= '0;
      o_rsp_fault          <= 1'b0;
      fe.dev_addr          <= '0;
      fe.reg_num           <= '0;
      fe.tx_data           <= '0;
      fe.read_len          <= '0;
      fe.read_len_wstrobe  <= 1'b0;
      fe.write_len         <= '0;
      fe.write_len_wstrobe <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt              <= '0;
`endif
    end else begin
      fe.read_len_wstrobe  <= 1'b0;
      fe.write_len_wstrobe <= 1'b0;
      o_rsp_valid          <= '0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= rr_idx;
            cur_write <= sel_write;
            rr_ptr    <= next_ptr;
            if (len_legal(sel_len)) begin
              // Strobe is registered here so it is high exactly during ISSUE.
              fe.dev_addr <= sel_dev;
              fe.reg_num  <= sel_reg;
              fe.tx_data  <= sel_tx;
              if (sel_write) begin
                fe.write_len         <= sel_len;
                fe.write_len_wstrobe <= 1'b1;
              end else begin
                fe.read_len          <= sel_len;
                fe.read_len_wstrobe  <= 1'b1;
              end
              state <= ST_ISSUE;
            end else begin
              o_rsp_valid <= rr_grant;
              o_rsp_fault <= 1'b1;
              o_rsp_data  <= '0;
              state       <= ST_RESPOND;
            end
          end
        end

        ST_ISSUE: begin
          start_cnt <= SW'(START_WAIT - 1);
`ifdef I2C_ARB_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= ST_WAIT_START;
        end

        ST_WAIT_START, ST_WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_cnt == TMO_LAST) begin
            o_rsp_valid <= owner_onehot;
            o_rsp_fault <= 1'b1;
            o_rsp_data  <= TIMEOUT_DATA;
            state       <= ST_RESPOND;
          end else
`endif
          if (state == ST_WAIT_START) begin
            // A front-end that finishes before we ever see it busy still
            // releases us once the start window expires.
            if (!fe_idle || start_cnt == '0) state <= ST_WAIT_DONE;
            else start_cnt <= start_cnt - 1'b1;
          end else if (fe_idle) begin
            o_rsp_valid <= owner_onehot;
            o_rsp_fault <= fe.status[1];
            o_rsp_data  <= cur_write ? '0 : fe.rx_data;
            state       <= ST_RESPOND;
          end
        end

        ST_RESPOND: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized self-checking bench for i2c_arbiter with a behavioural front-end
// and a queue-free round-robin reference model.
`timescale 1ns/1ps
module tb_i2c_arbiter;

  localparam int NREQ       = 4;
  localparam int START_WAIT = 16;
  localparam int TMO        = 100;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [6:0]           r_dev [NREQ];
  logic [7:0]           r_reg [NREQ];
  logic [2:0]           r_len [NREQ];
  logic [31:0]          r_tx  [NREQ];
  logic [7*NREQ-1:0]    dev_bus;
  logic [8*NREQ-1:0]    reg_bus;
  logic [3*NREQ-1:0]    len_bus;
  logic [32*NREQ-1:0]   tx_bus;
  logic [31:0]          rsp_data;
  logic                 rsp_fault;

  always_comb begin
    dev_bus = '0; reg_bus = '0; len_bus = '0; tx_bus = '0;
    for (int i = 0; i < NREQ; i++) begin
      dev_bus[i*7 +: 7]   = r_dev[i];
      reg_bus[i*8 +: 8]   = r_reg[i];
      len_bus[i*3 +: 3]   = r_len[i];
      tx_bus[i*32 +: 32]  = r_tx[i];
    end
  end

  i2c_arbiter_if fe();

  i2c_arbiter #(.NREQ(NREQ), .START_WAIT(START_WAIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_dev_addr (dev_bus),
    .i_req_reg_num  (reg_bus),
    .i_req_len      (len_bus),
    .i_req_tx_data  (tx_bus),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_fault    (rsp_fault),
    .fe             (fe)
  );

  // Behavioural front-end: busy window [drop, drop+len) cycles after a strobe.
  int          fe_drop = 2, fe_busy_len = 50;
  logic        fe_fault = 1'b0, fe_stuck = 1'b0;
  logic [31:0] fe_rx = '0;
  int          fe_t = -1, a_drop = 0, a_end = 0;
  logic        a_stuck = 1'b0;
  logic        fe_busy;

  always @(posedge clk) begin
    if (fe.read_len_wstrobe || fe.write_len_wstrobe) begin
      fe_t    <= 0;
      a_drop  <= fe_drop;
      a_end   <= fe_drop + fe_busy_len;
      a_stuck <= fe_stuck;
    end else if (fe_t >= 0 && fe_t < 100000) begin
      fe_t <= fe_t + 1;
    end
  end

  assign fe_busy    = (fe_t >= 0) && ((a_stuck && fe_stuck) || (fe_t >= a_drop && fe_t < a_end));
  assign fe.status  = {fe_fault, !fe_busy};
  assign fe.rx_data = fe_rx;

  int n_chk = 0, n_pass = 0;
  int m_ptr = 0;
  int wait_cnt [NREQ];
  int last_lat = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [2:0] len, input logic [31:0] tx);
    req_write[i] = wr; r_dev[i] = dev; r_reg[i] = rg; r_len[i] = len; r_tx[i] = tx;
    req_valid[i] = 1'b1;
    wait_cnt[i]  = 0;
  endtask

  task automatic rand_req(input int i, input bit allow_bad);
    logic [2:0] len;
    if (allow_bad && ($urandom % 6 == 0)) len = ($urandom % 2 == 0) ? 3'd0 : 3'(5 + $urandom % 3);
    else len = 3'(1 + $urandom % 4);
    set_req(i, 1'($urandom), 7'($urandom), 8'($urandom), len, $urandom);
  endtask

  task automatic post_hs(input int g, input bit refill, input bit allow_bad);
    if (refill) rand_req(g, allow_bad);
    else begin
      req_valid[g] = 1'b0;
      req_write[g] = 1'($urandom); r_dev[g] = 7'($urandom); r_reg[g] = 8'($urandom);
      r_len[g] = 3'($urandom); r_tx[g] = $urandom;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rsp"}, {req_ready, rsp_valid, rsp_fault, rsp_data}, '0);
    check({tag, "_fe"}, {fe.dev_addr, fe.reg_num, fe.read_len, fe.write_len,
                         fe.read_len_wstrobe, fe.write_len_wstrobe}, '0);
    check({tag, "_fe_tx"}, fe.tx_data, '0);
  endtask

  // Waits for a grant, predicts it, follows the transaction to its response.
  task automatic serve(input string tag, input bit refill, input bit allow_bad);
    int g, lat, n_rd, n_wr;
    bit got, legal;
    logic [6:0] sdev; logic [7:0] sreg; logic [2:0] slen; logic [31:0] stx; logic swr;
    logic [31:0] exp_data; logic exp_fault;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (req_ready != '0) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin check({tag, "_grant_wait"}, 0, 1); return; end
    g = model_pick(req_valid);
    if (g < 0) begin check({tag, "_grant"}, req_ready, 0); return; end
    check({tag, "_grant"}, req_ready, 64'(1) << g);
    check({tag, "_fair"}, 64'(wait_cnt[g] < NREQ), 1);
    for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) wait_cnt[i]++;
    wait_cnt[g] = 0;
    sdev = r_dev[g]; sreg = r_reg[g]; slen = r_len[g]; stx = r_tx[g]; swr = req_write[g];
    m_ptr = (g + 1) % NREQ;
    legal = (slen >= 1) && (slen <= 4);
    if (!legal)        begin exp_fault = 1'b1;     exp_data = '0; end
    else if (fe_stuck) begin exp_fault = 1'b1;     exp_data = 32'hFFFF_FFFF; end
    else               begin exp_fault = fe_fault; exp_data = swr ? '0 : fe_rx; end

    @(posedge clk);
    n_rd = 0; n_wr = 0; got = 0; lat = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (fe.read_len_wstrobe)  n_rd++;
      if (fe.write_len_wstrobe) n_wr++;
      if (fe.read_len_wstrobe || fe.write_len_wstrobe) begin
        check({tag, "_fe_fields"}, {fe.dev_addr, fe.reg_num, swr ? fe.write_len : fe.read_len},
              {sdev, sreg, slen});
        if (swr) check({tag, "_fe_tx"}, fe.tx_data, stx);
      end
      if (c == 1) post_hs(g, refill, allow_bad);
      if (rsp_valid != '0) begin got = 1; lat = c; break; end
    end
    if (!got) begin check({tag, "_rsp_wait"}, 0, 1); return; end
    last_lat = lat;
    check({tag, "_rsp_valid"}, rsp_valid, 64'(1) << g);
    check({tag, "_rsp_data"},  rsp_data, exp_data);
    check({tag, "_rsp_fault"}, rsp_fault, exp_fault);
    check({tag, "_strobes"}, {32'(n_rd), 32'(n_wr)},
          {32'(legal && !swr), 32'(legal && swr)});
    if (legal) check({tag, "_lat_min"}, 64'(lat >= 4), 1);
    else       check({tag, "_lat_bad"}, lat, 1);
    @(negedge clk);
    check({tag, "_rsp_pulse"}, rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*NREQ-1:0] seen;
    bit got;
    req_valid = '0; req_write = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_dev[i] = '0; r_reg[i] = '0; r_len[i] = '0; r_tx[i] = '0; wait_cnt[i] = 0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // Directed read and write
    fe_drop = 2; fe_busy_len = 50; fe_rx = 32'h0000_ABCD; fe_fault = 1'b0;
    set_req(1, 1'b0, 7'h50, 8'h10, 3'd2, 32'h0);
    serve("rd1", 0, 0);
    set_req(0, 1'b1, 7'h2A, 8'h44, 3'd4, 32'hDEAD_BEEF);
    serve("wr0", 0, 0);

    // All requesters continuously valid
    for (int i = 0; i < NREQ; i++) rand_req(i, 0);
    for (int n = 0; n < 2*NREQ; n++) begin
      fe_busy_len = 5 + int'($urandom % 10);
      fe_rx = $urandom;
      serve("rr", 1, 0);
    end
    for (int i = 0; i < NREQ; i++) req_valid[i] = 1'b0;

    // Illegal lengths, then a normal requester
    set_req(2, 1'b0, 7'h11, 8'h01, 3'd0, 32'h0);
    serve("len0", 0, 0);
    set_req(2, 1'b1, 7'h11, 8'h02, 3'd5, 32'h1234_5678);
    serve("len5", 0, 0);
    set_req(3, 1'b0, 7'h12, 8'h03, 3'd1, 32'h0);
    fe_rx = 32'h0000_00A5;
    serve("after_bad", 0, 0);

    // Front-end fault, then fast completion (never observed busy)
    fe_fault = 1'b1; fe_rx = 32'h5555_0000;
    set_req(3, 1'b0, 7'h13, 8'h04, 3'd3, 32'h0);
    serve("fault", 0, 0);
    fe_fault = 1'b0; fe_busy_len = 0; fe_rx = 32'h0BAD_F00D;
    set_req(1, 1'b0, 7'h14, 8'h05, 3'd4, 32'h0);
    serve("fast", 0, 0);
    check("fast_lat", 64'(last_lat > START_WAIT), 1);

`ifdef I2C_ARB_TIMEOUT_EN
    fe_stuck = 1'b1; fe_busy_len = 10;
    set_req(1, 1'b0, 7'h15, 8'h06, 3'd2, 32'h0);
    serve("tmo", 0, 0);
    check("tmo_lat", 64'(last_lat >= TMO), 1);
    set_req(0, 1'b1, 7'h16, 8'h07, 3'd1, 32'h77);
    seen = '0;
    repeat (20) begin #1; seen |= {req_ready, rsp_valid}; @(negedge clk); end
    check("tmo_block", seen, 0);
    fe_stuck = 1'b0;
    serve("tmo_after", 0, 0);
`endif

    // Reset while the front-end is busy
    fe_drop = 2; fe_busy_len = 60; fe_rx = 32'h1111_2222;
    set_req(1, 1'b0, 7'h22, 8'h33, 3'd3, 32'h0);
    got = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready != '0) begin got = 1; break; end
      @(negedge clk);
    end
    check("rst_mid_grant", req_ready, 64'(1) << model_pick(req_valid));
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 7'h23, 8'h34, 3'd2, 32'hCAFE_0001);
    set_req(2, 1'b0, 7'h24, 8'h35, 3'd1, 32'h0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_zero("rst_mid");
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    seen = '0;
    for (int c = 0; c < 200; c++) begin
      if (!fe_busy) break;
      seen |= {req_ready, rsp_valid};
      @(negedge clk);
    end
    check("rst_mid_quiet", seen, 0);
    fe_busy_len = 8;
    serve("post_rst0", 0, 0);
    serve("post_rst2", 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      fe_drop     = int'($urandom % 5);
      fe_busy_len = ($urandom % 5 == 0) ? 0 : int'(1 + $urandom % 40);
      fe_fault    = ($urandom % 8 == 0);
      fe_rx       = $urandom;
      for (int i = 0; i < NREQ; i++) if (!req_valid[i] && ($urandom % 2 == 0)) rand_req(i, 1);
      if ($urandom % 10 == 0) req_valid[$urandom % NREQ] = 1'b0;
      if (req_valid == '0) rand_req(int'($urandom % NREQ), 1);
      serve("rnd", 1'($urandom), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
